slv_guard_cfg_seq: RTL
======================

// Module: slv_guard_cfg_seq
// PURPOSE
// - Boot-time configuration sequencer for the slave guard register file. On start, writes the
//   eight budget registers (0x04..0x20) in ascending address order, then the enable register (0x00).
// - Drives a REG_BUS master port and asserts done_o, replacing the hand-written bench config loop.
// - Retries errored writes and flags unrecoverable failures, so the AXI master is released only
//   after the guard is fully configured.
// PARAMETERS
// - AddrWidth      32   reg bus address width
// - BaseAddr       0    guard register base; reg k is at BaseAddr+4*k
// - NumBudgets     8    budget regs at offsets 0x04..4*NumBudgets
// - MaxRetries     3    re-issues per register after reg_error_i (0 = no retry)
// - TimeoutCycles  256  cycles waiting for reg_ready_i before a timeout error; must be >= 2
// PORTS
// - clk_i          in   1                  clock
// - rst_i          in   1                  asynchronous reset, active-high
// - start_i        in   1                  pulse; starts a sequence when idle
// - enable_val_i   in   32                 value written to 0x00 (e.g. 32'h100)
// - budgets_i      in   32*NumBudgets      budget k at [32k+:32], written to BaseAddr+4*(k+1)
// - reg_addr_o     out  AddrWidth          reg bus address
// - reg_wdata_o    out  32                 reg bus write data
// - reg_wstrb_o    out  4                  always 4'hf
// - reg_write_o    out  1                  1 = write, 0 = read (read only with readback enabled)
// - reg_valid_o    out  1                  request valid
// - reg_ready_i    in   1                  request accepted / completed
// - reg_error_i    in   1                  error, sampled with reg_ready_i
// - reg_rdata_i    in   32                 read data, sampled with reg_ready_i
// - busy_o         out  1                  sequence in progress
// - done_o         out  1                  config complete; sticky until next start_i
// - err_o          out  1                  sequence aborted; sticky until next start_i
// - err_idx_o      out  4                  index of failing register (0 = enable, k+1 = budget k)
// BEHAVIOUR
// - Reset: all outputs 0. FSM goes to IDLE. Index, retry and timeout counters clear.
//   Reset mid-transfer drops reg_valid_o immediately (async).
// - FSM states: IDLE -> WR -> (RD) -> NEXT -> ... -> DONE | FAIL.
// - IDLE: start_i=1 latches budgets_i and enable_val_i, clears done_o/err_o, sets idx=1,
//   and enters WR next cycle. start_i while busy is ignored.
// - WR: reg_valid_o=1, reg_write_o=1. Address, data and write are held stable until reg_ready_i.
//   On ready with error=0: go to NEXT (or RD if readback enabled).
//   On ready with error=1: if retries<MaxRetries, increment retries, drop valid 1 cycle, re-enter WR;
//   else go to FAIL.
// - Timeout: timer counts cycles with valid=1 and ready=0. At TimeoutCycles, drop valid and go to FAIL
//   (no retry). Timer clears on every new request.
// - NEXT: 1 idle cycle with valid=0, retries=0. Index order is 1..NumBudgets, then 0.
//   After index 0 completes, go to DONE.
// - DONE: done_o=1, busy_o=0. Return to IDLE behaviour (accepts start_i).
// - FAIL: err_o=1, err_idx_o=failing idx, done_o=0, busy_o=0. Accepts start_i.
// - busy_o=1 in WR/RD/NEXT. Minimum time start->done with ready tied high:
//   2*(NumBudgets+1)+1 cycles (readback off).
// - Simultaneous ready and timeout expiry: ready wins.
// - err_idx_o is 4 bits wide, so NumBudgets <= 15.
// CONFIGURATION
// - SLV_GUARD_CFG_READBACK_EN defined: after each accepted write, RD state issues a read
//   (write=0) of the same address.
//   - rdata != written data, or error=1, is handled like a write error: retry restarts at WR,
//     then FAIL.
//   - The timeout applies to RD as well.
// - SLV_GUARD_CFG_READBACK_EN undefined: RD state and compare logic are absent;
//   reg_write_o is constant 1 while valid.
// TESTING
// - Ready tied 1, enable_val_i=32'h100, budgets {f,1,f,1,f,f,1,f}, start_i pulse ->
//   9 writes at 0x04,0x08..0x20 then 0x00 with matching data; done_o=1 after 19 cycles; err_o=0.
// - Ready delayed 3 cycles on 0x0c -> addr/wdata/valid stable all 3 cycles; sequence completes; done_o=1.
// - reg_error_i=1 on first two writes to 0x10, MaxRetries=3 -> 0x10 issued 3 times; done_o=1.
//   Same with 4 errors -> err_o=1, err_idx_o=4, 0x00 never written.
// - reg_ready_i stuck 0 on 0x18 -> valid drops after 256 cycles; err_o=1, err_idx_o=6, busy_o=0.
// - rst_i asserted mid-write to 0x14 -> valid and all outputs 0 the same cycle;
//   new start_i restarts at 0x04.
// - READBACK_EN, model returns rdata^1 once for 0x08 -> write, read, write, read of 0x08;
//   done_o=1. start_i during busy has no effect in all runs.

Source files
------------

// File: rtl/slv_guard_cfg_seq.sv
// Boot-time sequencer that writes the slave guard budget registers and then the enable register.
// Define SLV_GUARD_CFG_READBACK_EN to read back and compare every accepted write.
module slv_guard_cfg_seq #(
    parameter int unsigned          AddrWidth     = 32,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int unsigned          NumBudgets    = 8,
    parameter int unsigned          MaxRetries    = 3,
    parameter int unsigned          TimeoutCycles = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [31:0]               enable_val_i,
    input  logic [32*NumBudgets-1:0]  budgets_i,
    output logic [AddrWidth-1:0]      reg_addr_o,
    output logic [31:0]               reg_wdata_o,
    output logic [3:0]                reg_wstrb_o,
    output logic                      reg_write_o,
    output logic                      reg_valid_o,
    input  logic                      reg_ready_i,
    input  logic                      reg_error_i,
    input  logic [31:0]               reg_rdata_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [3:0]                err_idx_o
);

    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned TimerW = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
`ifdef SLV_GUARD_CFG_READBACK_EN
        S_RD    = 3'd2,
`endif
        S_RETRY = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_FAIL  = 3'd6
    } state_e;

    state_e                        state_r;
    logic [3:0]                    idx_r;
    logic [RetryW-1:0]             retry_r;
    logic [TimerW-1:0]             timer_r;
    // Slot 0 holds the enable value, slot k holds budget k-1, matching the register index.
    logic [32*(NumBudgets+1)-1:0]  cfg_vec_r;
    logic [3:0]                    next_idx_s;
    logic [31:0]                   next_data_s;
    logic                          rsp_bad_s;
    logic                          unused_rdata_s;

    assign unused_rdata_s = ^reg_rdata_i;

    function automatic logic [AddrWidth-1:0] reg_addr_f(input logic [3:0] idx);
        reg_addr_f = BaseAddr + AddrWidth'({idx, 2'b00});
    endfunction

    // Next register in program order and classification of the current response.
    always_comb begin
        if (idx_r == 4'(NumBudgets)) begin
            next_idx_s = 4'd0;
        end else begin
            next_idx_s = idx_r + 4'd1;
        end
        next_data_s = cfg_vec_r[{next_idx_s, 5'd0} +: 32];
`ifdef SLV_GUARD_CFG_READBACK_EN
        if (state_r == S_RD) begin
            rsp_bad_s = reg_error_i || (reg_rdata_i != reg_wdata_o);
        end else begin
            rsp_bad_s = reg_error_i;
        end
`else
        rsp_bad_s = reg_error_i;
`endif
    end

    // Sequencer FSM with all bus and status outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            idx_r       <= 4'd0;
            retry_r     <= '0;
            timer_r     <= '0;
            cfg_vec_r   <= '0;
            reg_addr_o  <= '0;
            reg_wdata_o <= 32'd0;
            reg_wstrb_o <= 4'h0;
            reg_write_o <= 1'b0;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_idx_o   <= 4'd0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        cfg_vec_r   <= {budgets_i, enable_val_i};
                        idx_r       <= 4'd1;
                        retry_r     <= '0;
                        timer_r     <= '0;
                        done_o      <= 1'b0;
                        err_o       <= 1'b0;
                        err_idx_o   <= 4'd0;
                        busy_o      <= 1'b1;
                        reg_addr_o  <= reg_addr_f(4'd1);
                        reg_wdata_o <= budgets_i[31:0];
                        reg_wstrb_o <= 4'hf;
                        reg_write_o <= 1'b1;
                        reg_valid_o <= 1'b1;
                        state_r     <= S_WR;
                    end else begin
                        state_r <= state_r;
                    end
                end

`ifdef SLV_GUARD_CFG_READBACK_EN
                S_WR, S_RD: begin
`else
                S_WR: begin
`endif
                    if (reg_ready_i) begin
                        if (rsp_bad_s) begin
                            reg_valid_o <= 1'b0;
                            if (retry_r < RetryW'(MaxRetries)) begin
                                retry_r <= retry_r + RetryW'(1'b1);
                                state_r <= S_RETRY;
                            end else begin
                                busy_o    <= 1'b0;
                                err_o     <= 1'b1;
                                err_idx_o <= idx_r;
                                state_r   <= S_FAIL;
                            end
                        end else begin
`ifdef SLV_GUARD_CFG_READBACK_EN
                            if (state_r == S_WR) begin
                                reg_write_o <= 1'b0;
                                timer_r     <= '0;
                                state_r     <= S_RD;
                            end else begin
                                reg_valid_o <= 1'b0;
                                state_r     <= S_NEXT;
                            end
`else
                            reg_valid_o <= 1'b0;
                            state_r     <= S_NEXT;
`endif
                        end
                    end else if (timer_r == TimerW'(TimeoutCycles - 1)) begin
                        // A stuck slave is not retried.
                        reg_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        err_o       <= 1'b1;
                        err_idx_o   <= idx_r;
                        state_r     <= S_FAIL;
                    end else begin
                        timer_r <= timer_r + TimerW'(1'b1);
                    end
                end

                S_RETRY: begin
                    timer_r     <= '0;
                    reg_write_o <= 1'b1;
                    reg_valid_o <= 1'b1;
                    state_r     <= S_WR;
                end

                S_NEXT: begin
                    retry_r <= '0;
                    if (idx_r == 4'd0) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        idx_r       <= next_idx_s;
                        timer_r     <= '0;
                        reg_addr_o  <= reg_addr_f(next_idx_s);
                        reg_wdata_o <= next_data_s;
                        reg_write_o <= 1'b1;
                        reg_valid_o <= 1'b1;
                        state_r     <= S_WR;
                    end
                end

                default: begin
                    reg_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
